// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter in front of the FPro MMIO bus.
// Each transaction is latched, issued as a single registered bus strobe and
// acknowledged one cycle later with the captured read data. Grants alternate
// (or favour M0 when FIXED_PRIO=1), and a master that latches lock=1 keeps
// the bus for its follow-up transaction so read-modify-write stays atomic.
module mmio_bus_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int AW = 21,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_rd,
  input  logic          m0_wr,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wr_data,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rd_data,
  input  logic          m1_req,
  input  logic          m1_rd,
  input  logic          m1_wr,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wr_data,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rd_data,
  output logic          mmio_cs,
  output logic          mmio_rd,
  output logic          mmio_wr,
  output logic [AW-1:0] mmio_addr,
  output logic [DW-1:0] mmio_wr_data,
  input  logic [DW-1:0] mmio_rd_data,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, LOCKED} state_t;

  state_t  state_reg;
  logic    rr_prefer_reg;   // master preferred on a simultaneous request
  logic    lat_rd_reg;
  logic    lat_wr_reg;
  logic    lat_lock_reg;

  logic          grant_valid;
  logic          grant_sel;
  logic          sel_rd;
  logic          sel_wr;
  logic          sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wr_data;
  logic          owner_lock_now;
  logic          issue_legal;
  logic [DW-1:0] issue_data;

  // Arbitration: who may start a transaction this cycle
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    case (state_reg)
      IDLE: begin
        grant_valid = m0_req | m1_req;
        if (m0_req && m1_req)
          grant_sel = (FIXED_PRIO != 0) ? 1'b0 : rr_prefer_reg;
        else
          grant_sel = m1_req;
      end
      LOCKED: begin
        // Only the lock holder is looked at; the other master waits
        grant_sel   = owner;
        grant_valid = owner ? m1_req : m0_req;
      end
      default: ;
    endcase
  end

  // Command mux for the selected master and data for the completion
  always_comb begin
    sel_rd         = grant_sel ? m1_rd      : m0_rd;
    sel_wr         = grant_sel ? m1_wr      : m0_wr;
    sel_lock       = grant_sel ? m1_lock    : m0_lock;
    sel_addr       = grant_sel ? m1_addr    : m0_addr;
    sel_wr_data    = grant_sel ? m1_wr_data : m0_wr_data;
    owner_lock_now = owner ? m1_lock : m0_lock;
    issue_legal    = lat_rd_reg ^ lat_wr_reg;
    issue_data     = (issue_legal && lat_rd_reg) ? mmio_rd_data : '0;
  end

  // Arbiter FSM with all bus and completion outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      rr_prefer_reg <= 1'b0;
      lat_rd_reg    <= 1'b0;
      lat_wr_reg    <= 1'b0;
      lat_lock_reg  <= 1'b0;
      owner         <= 1'b0;
      mmio_cs       <= 1'b0;
      mmio_rd       <= 1'b0;
      mmio_wr       <= 1'b0;
      mmio_addr     <= '0;
      mmio_wr_data  <= '0;
      m0_ack        <= 1'b0;
      m0_err        <= 1'b0;
      m0_rd_data    <= '0;
      m1_ack        <= 1'b0;
      m1_err        <= 1'b0;
      m1_rd_data    <= '0;
    end else begin
      case (state_reg)
        IDLE, LOCKED: begin
          if (grant_valid) begin
            owner        <= grant_sel;
            lat_rd_reg   <= sel_rd;
            lat_wr_reg   <= sel_wr;
            lat_lock_reg <= sel_lock;
            mmio_addr    <= sel_addr;
            mmio_wr_data <= sel_wr_data;
            // An illegal command never reaches the bus
            mmio_cs      <= sel_rd ^ sel_wr;
            mmio_rd      <= sel_rd & ~sel_wr;
            mmio_wr      <= sel_wr & ~sel_rd;
            state_reg    <= ISSUE;
          end else if (state_reg == LOCKED && !owner_lock_now) begin
            state_reg <= IDLE;
          end
        end
        ISSUE: begin
          mmio_cs <= 1'b0;
          mmio_rd <= 1'b0;
          mmio_wr <= 1'b0;
          if (owner) begin
            m1_ack     <= 1'b1;
            m1_err     <= ~issue_legal;
            m1_rd_data <= issue_data;
          end else begin
            m0_ack     <= 1'b1;
            m0_err     <= ~issue_legal;
            m0_rd_data <= issue_data;
          end
          state_reg <= ACK;
        end
        ACK: begin
          m0_ack        <= 1'b0;
          m0_err        <= 1'b0;
          m0_rd_data    <= '0;
          m1_ack        <= 1'b0;
          m1_err        <= 1'b0;
          m1_rd_data    <= '0;
          rr_prefer_reg <= ~owner;
          state_reg     <= lat_lock_reg ? LOCKED : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: a table of single-master
// transactions plus hand-written round-robin, lock, reset-abort and
// fixed-priority sequences. Bus strobes and acks are checked against
// scoreboard queues filled when stimulus is driven.
module tb_mmio_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 0, m0_rd = 0, m0_wr = 0, m0_lock = 0;
  logic [20:0] m0_addr = '0;
  logic [31:0] m0_wr_data = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rd_data;
  logic        m1_req = 0, m1_rd = 0, m1_wr = 0, m1_lock = 0;
  logic [20:0] m1_addr = '0;
  logic [31:0] m1_wr_data = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rd_data;
  logic        mmio_cs, mmio_rd, mmio_wr, owner;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data, mmio_rd_data;

  // Fixed-priority instance signals
  logic        fp_reset = 1'b0;
  logic        fp_req = 1'b0;
  logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
  logic [31:0] fp_m0_rd_data, fp_m1_rd_data;
  logic        fp_mmio_cs, fp_mmio_rd, fp_mmio_wr, fp_owner;
  logic [20:0] fp_mmio_addr;
  logic [31:0] fp_mmio_wr_data, fp_mmio_rd_data;

  always #5 clk = ~clk;

  // Slave model: combinational read data from the address
  function automatic logic [31:0] slave_fn(input logic [20:0] a);
    if (a == 21'h000040) return 32'h12345678;
    return {11'h0, a} ^ 32'hA5A5_0000;
  endfunction

  assign mmio_rd_data    = slave_fn(mmio_addr);
  assign fp_mmio_rd_data = slave_fn(fp_mmio_addr);

  mmio_bus_arbiter #(.FIXED_PRIO(0), .AW(21), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd_data(m1_rd_data),
    .mmio_cs(mmio_cs), .mmio_rd(mmio_rd), .mmio_wr(mmio_wr),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .owner(owner)
  );

  mmio_bus_arbiter #(.FIXED_PRIO(1), .AW(21), .DW(32)) dut_fp (
    .clk(clk), .reset(fp_reset),
    .m0_req(fp_req), .m0_rd(1'b1), .m0_wr(1'b0), .m0_lock(1'b0),
    .m0_addr(21'h000007), .m0_wr_data(32'h0),
    .m0_ack(fp_m0_ack), .m0_err(fp_m0_err), .m0_rd_data(fp_m0_rd_data),
    .m1_req(fp_req), .m1_rd(1'b1), .m1_wr(1'b0), .m1_lock(1'b0),
    .m1_addr(21'h000009), .m1_wr_data(32'h0),
    .m1_ack(fp_m1_ack), .m1_err(fp_m1_err), .m1_rd_data(fp_m1_rd_data),
    .mmio_cs(fp_mmio_cs), .mmio_rd(fp_mmio_rd), .mmio_wr(fp_mmio_wr),
    .mmio_addr(fp_mmio_addr), .mmio_wr_data(fp_mmio_wr_data),
    .mmio_rd_data(fp_mmio_rd_data), .owner(fp_owner)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wdata;
  } strobe_t;

  typedef struct {
    logic        m;
    logic        err;
    logic [31:0] rdata;
  } ack_t;

  typedef struct {
    logic        m;
    logic        rd;
    logic        wr;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  strobe_t sb_strobe[$];
  ack_t    sb_ack[$];
  vec_t    vecs[7];
  int      n_checks = 0;
  int      n_pass = 0;

  task automatic check(input bit ok, input string name, input string got, input string exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, got, exp);
  endtask

  task automatic drive(input logic m, input logic req, input logic rd, input logic wr,
                       input logic lock, input logic [20:0] addr, input logic [31:0] wd);
    if (!m) begin
      m0_req = req; m0_rd = rd; m0_wr = wr; m0_lock = lock; m0_addr = addr; m0_wr_data = wd;
    end else begin
      m1_req = req; m1_rd = rd; m1_wr = wr; m1_lock = lock; m1_addr = addr; m1_wr_data = wd;
    end
  endtask

  task automatic expect_txn(input logic m, input logic rd, input logic wr,
                            input logic [20:0] addr, input logic [31:0] wd);
    strobe_t s;
    ack_t    a;
    logic    legal;
    legal = rd ^ wr;
    if (legal) begin
      s.rd = rd; s.wr = wr; s.addr = addr; s.wdata = wd;
      sb_strobe.push_back(s);
    end
    a.m = m;
    a.err = ~legal;
    a.rdata = (legal && rd) ? slave_fn(addr) : 32'h0;
    sb_ack.push_back(a);
  endtask

  task automatic wait_ack(input logic m, input string tag);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((!m && m0_ack) || (m && m1_ack)) return;
    end
    check(1'b0, {tag, "_timeout"}, "no ack", "ack within 40 cycles");
  endtask

  // Single transaction from IDLE: ack exactly 3 sampled cycles after drive,
  // with exactly one cs cycle for a legal command and none for an illegal one
  task automatic run_vec(input vec_t v, input int idx);
    int cs_cnt;
    int lat;
    expect_txn(v.m, v.rd, v.wr, v.addr, v.wdata);
    drive(v.m, 1'b1, v.rd, v.wr, 1'b0, v.addr, v.wdata);
    cs_cnt = 0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mmio_cs) cs_cnt++;
      if ((!v.m && m0_ack) || (v.m && m1_ack)) begin
        lat = c;
        break;
      end
    end
    drive(v.m, 1'b0, 1'b0, 1'b0, 1'b0, v.addr, v.wdata);
    check(lat == 3 && cs_cnt == ((v.rd ^ v.wr) ? 1 : 0), $sformatf("vec%0d_timing", idx),
          $sformatf("ack_cycle=%0d cs_cycles=%0d", lat, cs_cnt),
          $sformatf("ack_cycle=3 cs_cycles=%0d", (v.rd ^ v.wr) ? 1 : 0));
    @(posedge clk); #1;
  endtask

  // Bus and completion monitor, compared against the scoreboard queues
  strobe_t mon_s;
  ack_t    mon_a;
  logic    mon_m, mon_err, mon_oth;
  logic [31:0] mon_rd;
  always @(negedge clk) begin
    if (mmio_cs || mmio_rd || mmio_wr) begin
      if (sb_strobe.size() == 0) begin
        check(1'b0, "strobe_unexpected", $sformatf("cs=%0b rd=%0b wr=%0b addr=%h",
              mmio_cs, mmio_rd, mmio_wr, mmio_addr), "no strobe");
      end else begin
        mon_s = sb_strobe.pop_front();
        check(mmio_cs && mmio_rd == mon_s.rd && mmio_wr == mon_s.wr &&
              mmio_addr == mon_s.addr && mmio_wr_data == mon_s.wdata, "strobe",
              $sformatf("cs=%0b rd=%0b wr=%0b addr=%h wd=%h", mmio_cs, mmio_rd, mmio_wr,
                        mmio_addr, mmio_wr_data),
              $sformatf("cs=1 rd=%0b wr=%0b addr=%h wd=%h", mon_s.rd, mon_s.wr,
                        mon_s.addr, mon_s.wdata));
      end
    end
    if (m0_ack || m1_ack) begin
      mon_m   = m1_ack;
      mon_err = mon_m ? m1_err : m0_err;
      mon_rd  = mon_m ? m1_rd_data : m0_rd_data;
      mon_oth = mon_m ? (m0_ack | m0_err | (|m0_rd_data)) : (m1_ack | m1_err | (|m1_rd_data));
      if (sb_ack.size() == 0) begin
        check(1'b0, "ack_unexpected", $sformatf("m%0d ack", mon_m), "no ack");
      end else begin
        mon_a = sb_ack.pop_front();
        check(mon_m == mon_a.m && mon_err == mon_a.err && mon_rd == mon_a.rdata &&
              !mon_oth && owner == mon_a.m, "ack",
              $sformatf("m%0d err=%0b rd=%h other_active=%0b owner=%0b", mon_m, mon_err,
                        mon_rd, mon_oth, owner),
              $sformatf("m%0d err=%0b rd=%h other_active=0 owner=%0b", mon_a.m, mon_a.err,
                        mon_a.rdata, mon_a.m));
      end
    end
  end

  function automatic bit all_zero();
    return !(m0_ack | m0_err | m1_ack | m1_err | mmio_cs | mmio_rd | mmio_wr | owner) &&
           m0_rd_data == 0 && m1_rd_data == 0 && mmio_addr == 0 && mmio_wr_data == 0;
  endfunction

  initial begin
    int fp_m0_cnt;
    int fp_bad;

    vecs[0] = '{m: 1'b0, rd: 1'b0, wr: 1'b1, addr: 21'h000100, wdata: 32'hDEADBEEF,
                exp_err: 1'b0, exp_rdata: 32'h0};
    vecs[1] = '{m: 1'b1, rd: 1'b1, wr: 1'b0, addr: 21'h000040, wdata: 32'h0,
                exp_err: 1'b0, exp_rdata: 32'h12345678};
    vecs[2] = '{m: 1'b0, rd: 1'b1, wr: 1'b0, addr: 21'h001234, wdata: 32'h0,
                exp_err: 1'b0, exp_rdata: 32'hA5A5_1234};
    vecs[3] = '{m: 1'b1, rd: 1'b0, wr: 1'b1, addr: 21'h1FFFFF, wdata: 32'hFFFFFFFF,
                exp_err: 1'b0, exp_rdata: 32'h0};
    vecs[4] = '{m: 1'b0, rd: 1'b1, wr: 1'b1, addr: 21'h000200, wdata: 32'h11111111,
                exp_err: 1'b1, exp_rdata: 32'h0};
    vecs[5] = '{m: 1'b1, rd: 1'b0, wr: 1'b0, addr: 21'h000300, wdata: 32'h22222222,
                exp_err: 1'b1, exp_rdata: 32'h0};
    vecs[6] = '{m: 1'b0, rd: 1'b1, wr: 1'b0, addr: 21'h000000, wdata: 32'h0,
                exp_err: 1'b0, exp_rdata: 32'hA5A5_0000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(all_zero(), "reset_state", "nonzero output", "all outputs 0");
    @(posedge clk); #1;
    reset = 1'b1;

    // Round-robin: both masters hold req, each presents a new command at its ack
    expect_txn(1'b0, 1'b1, 1'b0, 21'h000200, 32'h0);
    expect_txn(1'b1, 1'b1, 1'b0, 21'h000300, 32'h0);
    expect_txn(1'b0, 1'b1, 1'b0, 21'h000201, 32'h0);
    expect_txn(1'b1, 1'b1, 1'b0, 21'h000301, 32'h0);
    fork
      begin
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 21'h000200, 32'h0);
        wait_ack(1'b0, "rr_m0a");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 21'h000201, 32'h0);
        wait_ack(1'b0, "rr_m0b");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 21'h000201, 32'h0);
      end
      begin
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 21'h000300, 32'h0);
        wait_ack(1'b1, "rr_m1a");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 21'h000301, 32'h0);
        wait_ack(1'b1, "rr_m1b");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 21'h000301, 32'h0);
      end
    join
    @(posedge clk); #1;

    // Lock: M0 locked read then unlocked write; M1 waits until release
    expect_txn(1'b0, 1'b1, 1'b0, 21'h000010, 32'h0);
    expect_txn(1'b0, 1'b0, 1'b1, 21'h000011, 32'hCAFE0011);
    expect_txn(1'b1, 1'b0, 1'b1, 21'h000020, 32'hBEEF0020);
    fork
      begin
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 21'h000010, 32'h0);
        wait_ack(1'b0, "lock_m0rd");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 21'h000011, 32'hCAFE0011);
        wait_ack(1'b0, "lock_m0wr");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 21'h000011, 32'h0);
      end
      begin
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 21'h000020, 32'hBEEF0020);
        wait_ack(1'b1, "lock_m1wr");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 21'h000020, 32'h0);
      end
    join
    @(posedge clk); #1;

    // Table of single-master transactions
    for (int i = 0; i < 7; i++) begin
      check(((vecs[i].rd ^ vecs[i].wr) ? 1'b0 : 1'b1) == vecs[i].exp_err &&
            ((vecs[i].rd && !vecs[i].wr) ? slave_fn(vecs[i].addr) : 32'h0) == vecs[i].exp_rdata,
            $sformatf("vec%0d_table", i), "inconsistent table row", "consistent row");
      expect_txn(vecs[i].m, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      void'(sb_ack.pop_back());
      if ((vecs[i].rd ^ vecs[i].wr) == 1'b1) void'(sb_strobe.pop_back());
      run_vec(vecs[i], i);
    end

    // Reset asserted during ISSUE aborts the transaction
    sb_strobe.push_back('{rd: 1'b1, wr: 1'b0, addr: 21'h000080, wdata: 32'h0});
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 21'h000080, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check(mmio_cs == 1'b1, "abort_in_issue", $sformatf("cs=%0b", mmio_cs), "cs=1");
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 21'h000080, 32'h0);
    @(negedge clk);
    check(all_zero(), "abort_outputs", "nonzero output", "all outputs 0");
    @(negedge clk);
    check(!m0_ack && !m1_ack, "abort_no_ack", $sformatf("acks=%0b%0b", m0_ack, m1_ack), "acks=00");
    @(posedge clk); #1;
    reset = 1'b1;
    run_vec('{m: 1'b1, rd: 1'b1, wr: 1'b0, addr: 21'h000040, wdata: 32'h0,
              exp_err: 1'b0, exp_rdata: 32'h12345678}, 99);

    check(sb_strobe.size() == 0 && sb_ack.size() == 0, "scoreboard_empty",
          $sformatf("strobes=%0d acks=%0d", sb_strobe.size(), sb_ack.size()), "0 and 0");

    // Fixed priority: both request every cycle, M1 must starve
    fp_req = 1'b1;
    @(posedge clk); #1;
    fp_reset = 1'b1;
    fp_m0_cnt = 0;
    fp_bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (fp_m1_ack || fp_m1_err || fp_m1_rd_data != 0) fp_bad++;
      if (fp_mmio_cs && !(fp_mmio_rd && !fp_mmio_wr && fp_mmio_addr == 21'h000007 &&
                          fp_mmio_wr_data == 0)) fp_bad++;
      if (fp_m0_ack) begin
        fp_m0_cnt++;
        if (fp_m0_err || fp_owner || fp_m0_rd_data != slave_fn(21'h000007)) fp_bad++;
      end
    end
    check(fp_bad == 0, "fixed_prio_m1_starved", $sformatf("bad=%0d", fp_bad), "bad=0");
    check(fp_m0_cnt >= 4, "fixed_prio_m0_grants", $sformatf("%0d", fp_m0_cnt), ">=4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
